// File: rtl/itcm_responder_if.sv
// Fetch request/response channel between an instruction fetch initiator and the ITCM responder.
// The master modport is the fetch initiator; the slave modport is the responder.
interface itcm_responder_if #(
    parameter int XLEN = 64
);
    logic            fetch_req_valid;
    logic            fetch_req_ready;
    logic [XLEN-1:0] fetch_req_addr;
    logic            fetch_rsp_valid;
    logic            fetch_rsp_ready;
    logic [31:0]     fetch_rsp_data;
    logic            fetch_rsp_err;

    modport master (
        output fetch_req_valid,
        output fetch_req_addr,
        output fetch_rsp_ready,
        input  fetch_req_ready,
        input  fetch_rsp_valid,
        input  fetch_rsp_data,
        input  fetch_rsp_err
    );

    modport slave (
        input  fetch_req_valid,
        input  fetch_req_addr,
        input  fetch_rsp_ready,
        output fetch_req_ready,
        output fetch_rsp_valid,
        output fetch_rsp_data,
        output fetch_rsp_err
    );
endinterface

// File: rtl/itcm_responder.sv
// ITCM fetch responder: one-cycle RAM read feeding a 2-entry in-order response FIFO.
// Define ITCM_PRELOAD_EN to enable the byte-wide preload write port (load_*).
module itcm_responder #(
    parameter int AW   = 10,
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RST,
    itcm_responder_if.slave bus,
    input  logic            flush,
    input  logic            load_valid,
    input  logic [AW+1:0]   load_addr,
    input  logic [7:0]      load_byte
);
    localparam int DEPTH = 2**AW;

    logic [31:0] mem_q [DEPTH];

    logic        req_fire;
    logic        rsp_fire;
    logic        rsp_valid;
    logic        addr_err;
    logic        load_block;
    logic [2:0]  occupancy;

    logic        inflight_q, inflight_d;
    logic        inflight_err_q;
    logic [31:0] rdata_q;

    logic [31:0] fifo_data_q [2];
    logic        fifo_err_q  [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

`ifdef ITCM_PRELOAD_EN
    assign load_block = load_valid;

    always_ff @(posedge CLK) begin
        if (load_valid) begin
            mem_q[load_addr[AW+1:2]][{load_addr[1:0], 3'b000} +: 8] <= load_byte;
        end
    end
`else
    logic unused_load;
    assign load_block  = 1'b0;
    assign unused_load = ^{load_valid, load_addr, load_byte};
`endif

    // Misaligned or beyond the last ITCM word both fault.
    assign addr_err = (bus.fetch_req_addr[1:0] != 2'b00) ||
                      (bus.fetch_req_addr[XLEN-1:AW+2] != '0);

    assign rsp_valid = (count_q != 2'd0);
    assign rsp_fire  = rsp_valid && bus.fetch_rsp_ready;

    // Slots already claimed once this cycle's pop is taken into account.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, rsp_fire};

    assign bus.fetch_req_ready = !RST && !flush && !load_block && (occupancy < 3'd2);
    assign req_fire            = bus.fetch_req_valid && bus.fetch_req_ready;

    assign bus.fetch_rsp_valid = rsp_valid;
    assign bus.fetch_rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign bus.fetch_rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

    always_comb begin
        inflight_d = req_fire;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            inflight_d = 1'b0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (inflight_q) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (rsp_fire) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({inflight_q, rsp_fire})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Read stage captures the RAM word; the next edge pushes it (zeroed on fault) into the FIFO.
    always_ff @(posedge CLK) begin
        if (req_fire) begin
            rdata_q        <= mem_q[bus.fetch_req_addr[AW+1:2]];
            inflight_err_q <= addr_err;
        end
        if (inflight_q && !flush) begin
            fifo_data_q[wr_ptr_q] <= inflight_err_q ? 32'h0 : rdata_q;
            fifo_err_q[wr_ptr_q]  <= inflight_err_q;
        end
    end
endmodule

// File: doc/itcm_responder.md
ITCM_RESPONDER -- requirements
Module: itcm_responder

Interface
REQ-001 Parameter AW, default 10, ITCM word-address width; depth is 2**AW 32-bit words.
REQ-002 Parameter XLEN, default 64, fetch request address width.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 fetch_req_valid  input  1  initiator presents a fetch request.
REQ-006 fetch_req_ready  output  1  responder accepts the request this cycle.
REQ-007 fetch_req_addr  input  XLEN  byte address of the instruction word.
REQ-008 fetch_rsp_valid  output  1  response word available.
REQ-009 fetch_rsp_ready  input  1  initiator consumes the response.
REQ-010 fetch_rsp_data  output  32  instruction word, little-endian.
REQ-011 fetch_rsp_err  output  1  access fault for this response.
REQ-012 flush  input  1  discard all in-flight and buffered responses.
REQ-013 load_valid  input  1  preload byte write strobe.
REQ-014 load_addr  input  AW+2  preload byte address.
REQ-015 load_byte  input  8  preload byte data.

Function
REQ-016 A request SHALL be accepted when fetch_req_valid and fetch_req_ready are both 1 on a rising edge.
REQ-017 The RAM read SHALL take one cycle; the result SHALL enter a 2-entry response FIFO the cycle after acceptance.
REQ-018 fetch_rsp_valid SHALL be 1 whenever the FIFO is non-empty, presenting the oldest entry; an entry SHALL pop when fetch_rsp_valid and fetch_rsp_ready are both 1.
REQ-019 fetch_req_ready SHALL be 1 iff flush=0, load_valid=0 and (FIFO count + in-flight read - pop this cycle) < 2; combinational dependence on fetch_rsp_ready is permitted.
REQ-020 With fetch_rsp_ready held 1, back-to-back requests SHALL sustain one response per cycle; first response is valid 2 cycles after acceptance.
REQ-021 Responses SHALL return in request order; the FIFO SHALL never overflow or underflow.
REQ-022 If fetch_req_addr[1:0]!=0 or fetch_req_addr >= 4*2**AW, the response SHALL carry fetch_rsp_err=1 and fetch_rsp_data=0 with the same latency; otherwise err=0 and data = ram[fetch_req_addr[AW+1:2]].
REQ-023 flush=1 SHALL empty the FIFO and cancel the in-flight read on that edge; fetch_rsp_valid SHALL be 0 the following cycle and no cancelled response SHALL ever appear.
REQ-024 A pop and a push in the same cycle SHALL leave the count unchanged.
REQ-025 load_valid=1 SHALL write load_byte into byte lane load_addr[1:0] of word load_addr[AW+1:2] on that edge; other lanes are unchanged.
REQ-026 load_valid SHALL take priority over fetch: no request is accepted in a cycle with load_valid=1; responses already buffered still drain.
REQ-027 A fetch accepted the cycle after a preload write to the same word SHALL return the updated word.

Reset
REQ-028 RST=1 SHALL immediately clear the FIFO, in-flight flag and pointers; fetch_rsp_valid=0, fetch_rsp_err=0, fetch_rsp_data=0, fetch_req_ready=0 while RST=1.
REQ-029 RAM contents SHALL NOT be altered by reset.
REQ-030 Reset asserted mid-transfer SHALL drop all pending responses; none SHALL appear after release.

Configuration
REQ-031 Macro ITCM_PRELOAD_EN defined: preload port functions per REQ-025..REQ-027.
REQ-032 ITCM_PRELOAD_EN undefined: load_* ports SHALL remain present but be ignored, no RAM write path SHALL exist, and fetch_req_ready SHALL not depend on load_valid.

Verification
REQ-033 Preload bytes 0x13,0x05,0x10,0x00 to addresses 0..3, fetch 0x0 -> one response data=0x00100513, err=0, valid 2 cycles after acceptance.
REQ-034 Eight back-to-back fetches 0x0..0x1C, rsp_ready=1 -> eight consecutive valid cycles, in address order.
REQ-035 rsp_ready=0 with continuous requests -> exactly 2 accepted, req_ready=0 thereafter; raise rsp_ready -> both drain in order, then acceptance resumes.
REQ-036 Fetch 0x2 and 0x1000 (AW=10) -> both responses err=1, data=0.
REQ-037 Two requests outstanding, flush=1 for one cycle -> rsp_valid=0 next cycle, neither response ever returned; next fetch returns normally.
REQ-038 RST pulsed with FIFO full -> outputs zero immediately; after release, fetch 0x0 still returns 0x00100513.
